moving_average: RTL and testbench

Streaming boxcar (moving-average) low-pass stage sitting directly downstream of `gain` in the audio/DSP chain. It consumes signed samples qualified by a valid strobe, keeps the most recent `2**LOG2_TAPS` samples in a circular delay line, and emits the running mean one cycle after each accepted sample. The sum is updated incrementally (add newest, subtract oldest), so there is no per-tap adder tree.

---
 rtl/moving_average_pkg.sv | 19 +
 rtl/moving_average_sample_ring.sv | 35 +++
 rtl/moving_average.sv | 100 ++++++++++
 tb/tb_moving_average.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/moving_average_pkg.sv
// Shared constants and types for the moving_average boxcar filter.
// The FSM state type is only used when MOVING_AVERAGE_WARMUP_EN is defined.
package moving_average_pkg;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_LOG2_TAPS = 3;
    localparam int TAPS              = 1 << DEFAULT_LOG2_TAPS;
    localparam int ACC_W             = DEFAULT_DATA_W + DEFAULT_LOG2_TAPS;

    typedef enum logic {
        FILL,
        RUN
    } fill_state_t;

    function automatic int unsigned taps_of(input int unsigned log2_taps);
        return 32'd1 << log2_taps;
    endfunction

endpackage

// File: rtl/moving_average_sample_ring.sv
// Circular delay line holding the most recent 2**LOG2_TAPS samples.
// The entry about to be overwritten is presented combinationally on oldest.
module sample_ring
    import moving_average_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int LOG2_TAPS = DEFAULT_LOG2_TAPS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] oldest
);

    localparam int unsigned TAPS_N = taps_of(LOG2_TAPS);

    logic signed [DATA_W-1:0] taps_mem [TAPS_N];
    logic [LOG2_TAPS-1:0]     wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS_N; i++) begin
                taps_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            taps_mem[wr_ptr] <= wr_data;
            wr_ptr           <= wr_ptr + 1'b1;
        end
    end

    assign oldest = taps_mem[wr_ptr];

endmodule

// File: rtl/moving_average.sv
// Streaming boxcar mean: running sum updated by add-newest/subtract-oldest.
// Define MOVING_AVERAGE_WARMUP_EN to suppress o_valid until the window is full.
module moving_average
    import moving_average_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int LOG2_TAPS = DEFAULT_LOG2_TAPS
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data
);

    localparam int ACC_BITS = DATA_W + LOG2_TAPS;

    logic signed [DATA_W-1:0]   oldest;
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] acc_next;
    logic signed [ACC_BITS-1:0] sample_ext;
    logic signed [ACC_BITS-1:0] oldest_ext;
    logic                       emit;

    sample_ring #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_ring (
        .clk     (i_clk),
        .reset   (i_reset),
        .wr_en   (i_valid),
        .wr_data (i_data),
        .oldest  (oldest)
    );

    assign sample_ext = ACC_BITS'(i_data);
    assign oldest_ext = ACC_BITS'(oldest);
    assign acc_next   = acc + sample_ext - oldest_ext;

`ifdef MOVING_AVERAGE_WARMUP_EN
    localparam int unsigned TAPS_N = taps_of(LOG2_TAPS);

    fill_state_t          state;
    fill_state_t          state_next;
    logic [LOG2_TAPS:0]   fill_cnt;
    logic [LOG2_TAPS:0]   fill_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= FILL;
            fill_cnt <= '0;
        end else begin
            state    <= state_next;
            fill_cnt <= fill_cnt_next;
        end
    end

    // The sample that completes the window is the first one allowed to emit.
    always_comb begin
        state_next    = state;
        fill_cnt_next = fill_cnt;
        emit          = 1'b0;
        case (state)
            FILL: begin
                if (i_valid) begin
                    fill_cnt_next = fill_cnt + 1'b1;
                    if (fill_cnt == (LOG2_TAPS+1)'(TAPS_N - 1)) begin
                        state_next = RUN;
                        emit       = 1'b1;
                    end
                end
            end
            RUN: begin
                emit = i_valid;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end
`else
    assign emit = i_valid;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_valid) begin
            acc     <= acc_next;
            o_valid <= emit;
            o_data  <= DATA_W'(acc_next >>> LOG2_TAPS);
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average.sv
// Scoreboard bench for moving_average: a window-sum reference model predicts each
// output and its due cycle; a negedge monitor checks data, timing, hold and reset.
module tb_moving_average;

    localparam int DATA_W    = 8;
    localparam int LOG2_TAPS = 3;
    localparam int TAPS      = 8;
`ifdef MOVING_AVERAGE_WARMUP_EN
    localparam bit WARMUP = 1'b1;
`else
    localparam bit WARMUP = 1'b0;
`endif

    typedef struct {
        logic signed [DATA_W-1:0] data;
        int                       due;
    } exp_t;

    logic                     i_clk = 1'b0;
    logic                     i_reset = 1'b1;
    logic                     i_valid = 1'b0;
    logic signed [DATA_W-1:0] i_data = '0;
    logic                     o_valid;
    logic signed [DATA_W-1:0] o_data;

    always #5 i_clk = ~i_clk;

    moving_average #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fill   = 0;
    int hist[$];
    exp_t exp_q[$];

    logic                     rst_q = 1'b1;
    bit                       started = 1'b0;
    bit                       running = 1'b0;
    logic signed [DATA_W-1:0] last_out = '0;

    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_reset;
    end

    // Mean of the last TAPS accepted samples (zeros before history), floored toward -inf.
    function automatic logic signed [DATA_W-1:0] model_mean();
        int sum;
        int q;
        logic signed [31:0] q32;
        sum = 0;
        foreach (hist[k]) sum += hist[k];
        q = sum / TAPS;
        if ((sum % TAPS) != 0 && sum < 0) q = q - 1;
        q32 = q;
        return q32[DATA_W-1:0];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < TAPS; k++) hist.push_back(0);
        fill = 0;
    endtask

    task automatic drive(input bit rst, input bit v, input logic signed [DATA_W-1:0] d);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_reset = rst;
        i_valid = v;
        i_data  = d;
        if (rst) begin
            model_reset();
        end else if (v) begin
            hist.push_front(int'(d));
            void'(hist.pop_back());
            fill++;
            if (!WARMUP || fill >= TAPS) begin
                e.data = model_mean();
                e.due  = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_const(input int n, input logic signed [DATA_W-1:0] d);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, d);
    endtask

    always @(negedge i_clk) begin
        if (started) begin
            if (rst_q) begin
                checks++;
                if (o_valid !== 1'b0 || o_data !== '0) begin
                    errors++;
                    $display("FAIL reset_state: o_valid=%b o_data=%0d, required 0/0", o_valid, o_data);
                end
                last_out = '0;
                running  = 1'b0;
            end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (o_valid !== 1'b1 || o_data !== e.data) begin
                    errors++;
                    $display("FAIL output@%0d: o_valid=%b o_data=%0d, required 1/%0d", cyc, o_valid, o_data, e.data);
                end
                last_out = e.data;
                running  = 1'b1;
            end else begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_valid@%0d: o_valid=%b, required 0", cyc, o_valid);
                end else if ((!WARMUP || running) && o_data !== last_out) begin
                    errors++;
                    $display("FAIL hold@%0d: o_data=%0d, required %0d", cyc, o_data, last_out);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic signed [DATA_W-1:0] d;
        model_reset();
        drive(1'b1, 1'b0, '0);
        started = 1'b1;
        drive(1'b1, 1'b1, 8'sh55);

        // impulse
        drive(1'b0, 1'b1, 8'sh40);
        run_const(11, 8'sh00);
        drive(1'b1, 1'b0, '0);
        // step
        run_const(10, 8'sh10);
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        // negative floor
        run_const(10, -8'sd3);
        drive(1'b1, 1'b0, '0);
        // extremes
        run_const(8, 8'sh7F);
        run_const(10, -8'sd128);
        run_const(8, 8'sh7F);
        drive(1'b1, 1'b0, '0);
        // bubbles
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 8'sh10);
            drive(1'b0, 1'b0, 8'sh33);
        end
        // reset mid-stream, with a sample presented alongside reset
        drive(1'b1, 1'b0, '0);
        run_const(5, 8'sh10);
        drive(1'b1, 1'b1, 8'sh70);
        run_const(9, 8'sh10);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 59);
            case ($urandom_range(0, 3))
                0:       d = 8'sh7F;
                1:       d = -8'sd128;
                default: d = DATA_W'($urandom);
            endcase
            drive(r == 0, $urandom_range(0, 3) != 0, d);
        end

        repeat (4) drive(1'b0, 1'b0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
